grn_node_bank: RTL and testbench

//   Parametrised bank of N_NODES gene-regulatory-network nodes; successor to the two-register, single-bit GRN node.

---
 rtl/grn_node_bank.sv | 114 +++++++++++
 tb/tb_grn_node_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grn_node_bank.sv
// Bank of gene-regulatory-network nodes: current state s0 steps from an external next-state vector
// at a programmable period (synchronous or round-robin), with snapshot s1, step count and fixed-point flag.
module grn_node_bank #(
  parameter int N_NODES  = 8,
  parameter int PERIOD_W = 4,
  parameter int STEP_W   = 16,
  parameter int MODE     = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                reset_nos_i,
  input  logic [N_NODES-1:0]  init_state_i,
  input  logic [N_NODES-1:0]  next_state_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                start_s0_i,
  input  logic                start_s1_i,
  output logic [N_NODES-1:0]  s0_o,
  output logic [N_NODES-1:0]  s1_o,
  output logic [STEP_W-1:0]   step_cnt_o,
  output logic                fixed_point_o
);

  localparam int RR_W = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam int SC_W = $clog2(N_NODES + 1);

  logic [N_NODES-1:0]  s0_q, s0_d;
  logic [N_NODES-1:0]  s1_q, s1_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [RR_W-1:0]     rr_q, rr_d;
  logic [SC_W-1:0]     stable_q, stable_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                fp_q, fp_d;
  logic [PERIOD_W-1:0] period_eff;
  logic                do_update;

  assign period_eff = (period_i == '0) ? PERIOD_W'(1) : period_i;

  always_comb begin
    s0_d      = s0_q;
    s1_d      = s1_q;
    phase_d   = phase_q;
    rr_d      = rr_q;
    stable_d  = stable_q;
    step_d    = step_q;
    fp_d      = fp_q;
    do_update = 1'b0;

    if (reset_nos_i) begin
      s0_d     = init_state_i;
      s1_d     = init_state_i;
      phase_d  = '0;
      rr_d     = '0;
      stable_d = '0;
      step_d   = '0;
      fp_d     = 1'b0;
    end else begin
      // s1 always captures the pre-step value of s0
      if (start_s1_i) s1_d = s0_q;

      if (start_s0_i) begin
        if (phase_q == '0) begin
          do_update = 1'b1;
          phase_d   = period_eff - PERIOD_W'(1);
        end else begin
          phase_d = phase_q - PERIOD_W'(1);
        end
      end

      if (do_update) begin
        if (step_q != '1) step_d = step_q + 1'b1;

        if (MODE == 0) begin
          s0_d = next_state_i;
          fp_d = (next_state_i == s0_q);
        end else begin
          s0_d[rr_q] = next_state_i[rr_q];
          rr_d       = (rr_q == RR_W'(N_NODES - 1)) ? '0 : rr_q + 1'b1;
          if (next_state_i[rr_q] == s0_q[rr_q]) begin
            stable_d = (stable_q == SC_W'(N_NODES)) ? stable_q : stable_q + 1'b1;
          end else begin
            stable_d = '0;
          end
          fp_d = (stable_d == SC_W'(N_NODES));
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s0_q     <= '0;
      s1_q     <= '0;
      phase_q  <= '0;
      rr_q     <= '0;
      stable_q <= '0;
      step_q   <= '0;
      fp_q     <= 1'b0;
    end else begin
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      phase_q  <= phase_d;
      rr_q     <= rr_d;
      stable_q <= stable_d;
      step_q   <= step_d;
      fp_q     <= fp_d;
    end
  end

  assign s0_o          = s0_q;
  assign s1_o          = s1_q;
  assign step_cnt_o    = step_q;
  assign fixed_point_o = fp_q;

endmodule

// File: tb/tb_grn_node_bank.sv
// Bench for grn_node_bank: two synchronous-mode banks (wide and 2-bit step counters) sharing stimulus,
// plus a 4-node round-robin bank, all compared each cycle against an abstract reference model.
module tb_grn_node_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // synchronous banks A (STEP_W=16) and C (STEP_W=2) share inputs
  logic       rn_a = 0, st0_a = 0, st1_a = 0;
  logic [7:0] init_a = '0, nx_a = '0;
  logic [3:0] per_a = 4'd1;
  logic [7:0] s0_a, s1_a, s0_c, s1_c;
  logic [15:0] step_a;
  logic [1:0]  step_c;
  logic        fp_a, fp_c;

  // round-robin bank B, 4 nodes
  logic       rn_b = 0, st0_b = 0, st1_b = 0;
  logic [3:0] init_b = '0, nx_b = '0;
  logic [3:0] per_b = 4'd1;
  logic [3:0] s0_b, s1_b;
  logic [15:0] step_b;
  logic        fp_b;

  grn_node_bank #(.N_NODES(8), .PERIOD_W(4), .STEP_W(16), .MODE(0)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .reset_nos_i(rn_a), .init_state_i(init_a), .next_state_i(nx_a),
    .period_i(per_a), .start_s0_i(st0_a), .start_s1_i(st1_a),
    .s0_o(s0_a), .s1_o(s1_a), .step_cnt_o(step_a), .fixed_point_o(fp_a));

  grn_node_bank #(.N_NODES(8), .PERIOD_W(4), .STEP_W(2), .MODE(0)) dut_c (
    .clk_i(clk), .rst_i(rst_n), .reset_nos_i(rn_a), .init_state_i(init_a), .next_state_i(nx_a),
    .period_i(per_a), .start_s0_i(st0_a), .start_s1_i(st1_a),
    .s0_o(s0_c), .s1_o(s1_c), .step_cnt_o(step_c), .fixed_point_o(fp_c));

  grn_node_bank #(.N_NODES(4), .PERIOD_W(4), .STEP_W(16), .MODE(1)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .reset_nos_i(rn_b), .init_state_i(init_b), .next_state_i(nx_b),
    .period_i(per_b), .start_s0_i(st0_b), .start_s1_i(st1_b),
    .s0_o(s0_b), .s1_o(s1_b), .step_cnt_o(step_b), .fixed_point_o(fp_b));

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  logic [7:0] ma_s0 = '0, ma_s1 = '0;
  int         ma_step = 0, ma_wait = 0;
  logic       ma_fp = 1'b0;
  logic [3:0] mb_s0 = '0, mb_s1 = '0;
  int         mb_upd = 0, mb_wait = 0;
  logic       mb_fp = 1'b0;
  bit         mb_hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int eff_period(input logic [3:0] p);
    return (p == 0) ? 1 : int'(p);
  endfunction

  task automatic model_clear();
    ma_s0 = '0; ma_s1 = '0; ma_step = 0; ma_wait = 0; ma_fp = 1'b0;
    mb_s0 = '0; mb_s1 = '0; mb_upd = 0; mb_wait = 0; mb_fp = 1'b0;
    mb_hist.delete();
  endtask

  task automatic compare_all();
    chk("a_s0", 32'(s0_a), 32'(ma_s0));
    chk("a_s1", 32'(s1_a), 32'(ma_s1));
    chk("a_step", 32'(step_a), 32'(sat(ma_step, 65535)));
    chk("a_fp", 32'(fp_a), 32'(ma_fp));
    chk("c_s0", 32'(s0_c), 32'(ma_s0));
    chk("c_step", 32'(step_c), 32'(sat(ma_step, 3)));
    chk("c_fp", 32'(fp_c), 32'(ma_fp));
    chk("b_s0", 32'(s0_b), 32'(mb_s0));
    chk("b_s1", 32'(s1_b), 32'(mb_s1));
    chk("b_step", 32'(step_b), 32'(sat(mb_upd, 65535)));
    chk("b_fp", 32'(fp_b), 32'(mb_fp));
  endtask

  // one clock: capture inputs, edge, advance model, then compare away from the edge
  task automatic tick();
    logic       c_rna, c_s0a, c_s1a, c_rnb, c_s0b, c_s1b, changed;
    logic [7:0] c_inita, c_nxa;
    logic [3:0] c_pera, c_initb, c_nxb, c_perb;
    int         idx;
    c_rna = rn_a; c_s0a = st0_a; c_s1a = st1_a; c_inita = init_a; c_nxa = nx_a; c_pera = per_a;
    c_rnb = rn_b; c_s0b = st0_b; c_s1b = st1_b; c_initb = init_b; c_nxb = nx_b; c_perb = per_b;
    @(posedge clk);
    if (c_rna) begin
      ma_s0 = c_inita; ma_s1 = c_inita; ma_step = 0; ma_wait = 0; ma_fp = 1'b0;
    end else begin
      if (c_s1a) ma_s1 = ma_s0;
      if (c_s0a) begin
        if (ma_wait == 0) begin
          ma_fp = (c_nxa == ma_s0);
          ma_s0 = c_nxa;
          ma_step++;
          ma_wait = eff_period(c_pera) - 1;
        end else begin
          ma_wait--;
        end
      end
    end
    if (c_rnb) begin
      mb_s0 = c_initb; mb_s1 = c_initb; mb_upd = 0; mb_wait = 0; mb_fp = 1'b0;
      mb_hist.delete();
    end else begin
      if (c_s1b) mb_s1 = mb_s0;
      if (c_s0b) begin
        if (mb_wait == 0) begin
          idx = mb_upd % 4;
          changed = (c_nxb[idx] != mb_s0[idx]);
          mb_s0[idx] = c_nxb[idx];
          mb_hist.push_back(changed);
          if (mb_hist.size() > 4) void'(mb_hist.pop_front());
          // fixed point: the last four single-node updates all left their bit unchanged
          mb_fp = (mb_hist.size() == 4);
          foreach (mb_hist[k]) if (mb_hist[k]) mb_fp = 1'b0;
          mb_upd++;
          mb_wait = eff_period(c_perb) - 1;
        end else begin
          mb_wait--;
        end
      end
    end
    #1;
    compare_all();
  endtask

  initial begin
    logic [7:0] aexp[3];
    logic [3:0] bexp[4];
    aexp = '{8'h5A, 8'hA5, 8'h5A};
    bexp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

    // power-on reset
    #3;
    compare_all();
    #4 rst_n = 1'b1;

    // alternating next_state, period 1
    init_a = 8'hA5; rn_a = 1'b1;
    tick();
    chk("init_a5", 32'(s0_a), 32'h A5);
    rn_a = 1'b0; per_a = 4'd1; st0_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nx_a = ~ma_s0;
      tick();
      chk("toggle_seq", 32'(s0_a), 32'(aexp[i]));
    end
    chk("toggle_step", 32'(step_a), 32'd3);
    chk("toggle_fp", 32'(fp_a), 32'd0);

    // period 3: updates on starts 1, 4, 7
    st0_a = 1'b0; rn_a = 1'b1; tick();
    rn_a = 1'b0; per_a = 4'd3; st0_a = 1'b1;
    for (int i = 0; i < 7; i++) begin
      nx_a = ~ma_s0;
      tick();
      chk("period3_step", 32'(step_a), 32'((i / 3) + 1));
    end

    // fixed point detect and release
    st0_a = 1'b0; init_a = 8'h3C; rn_a = 1'b1; tick();
    rn_a = 1'b0; per_a = 4'd1; st0_a = 1'b1; nx_a = 8'h3C;
    tick();
    chk("fp_set", 32'(fp_a), 32'd1);
    nx_a = 8'h3D;
    tick();
    chk("fp_clear", 32'(fp_a), 32'd0);
    st0_a = 1'b0;

    // round-robin bank: fill with ones, then a quiet sweep
    init_b = 4'b0000; rn_b = 1'b1; tick();
    rn_b = 1'b0; nx_b = 4'b1111; st0_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_fill", 32'(s0_b), 32'(bexp[i]));
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_fp", 32'(fp_b), 32'(i == 3));
    end
    st0_b = 1'b0;

    // simultaneous snapshot and step, then step counter saturation on the 2-bit bank
    init_a = 8'h0F; rn_a = 1'b1; tick();
    rn_a = 1'b0; nx_a = 8'hF0; st0_a = 1'b1; st1_a = 1'b1;
    tick();
    chk("snap_s1", 32'(s1_a), 32'h0F);
    chk("snap_s0", 32'(s0_a), 32'hF0);
    st1_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nx_a = ~ma_s0;
      tick();
    end
    chk("sat_step_c", 32'(step_c), 32'd3);
    chk("sat_step_a", 32'(step_a), 32'd5);

    // async reset mid-countdown with fixed point set
    per_a = 4'd3; nx_a = ma_s0;
    tick();
    chk("pre_rst_fp", 32'(fp_a), 32'd1);
    st0_a = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    compare_all();
    #2 rst_n = 1'b1;
    init_a = 8'h66; rn_a = 1'b1; st0_a = 1'b1; nx_a = 8'h99;
    init_b = 4'h9;  rn_b = 1'b1; st0_b = 1'b1; nx_b = 4'h6;
    tick();
    chk("rnos_over_start", 32'(s0_a), 32'h66);
    chk("rnos_no_step", 32'(step_a), 32'd0);
    rn_a = 1'b0; rn_b = 1'b0; st0_a = 1'b0; st0_b = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rn_a   = ($urandom_range(0, 40) == 0);
      rn_b   = ($urandom_range(0, 40) == 0);
      init_a = 8'($urandom);
      init_b = 4'($urandom);
      per_a  = 4'($urandom_range(0, 3));
      per_b  = 4'($urandom_range(0, 2));
      st0_a  = ($urandom_range(0, 9) < 7);
      st1_a  = ($urandom_range(0, 9) < 3);
      st0_b  = ($urandom_range(0, 9) < 7);
      st1_b  = ($urandom_range(0, 9) < 3);
      nx_a   = ($urandom_range(0, 1) == 0) ? ma_s0 : 8'($urandom);
      nx_b   = ($urandom_range(0, 3) != 0) ? mb_s0 : (mb_s0 ^ (4'b0001 << $urandom_range(0, 3)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
